// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Uses the req/gnt/rvalid protocol; read data is returned only for loads.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs one data-memory access per load/store with byte-lane steering,
// load extension, timeout abort and upstream stall; other instructions pass through to WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_busb,
    input  logic        ex_memrd,
    input  logic        ex_memwr,
    input  logic [2:0]  ex_memop,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwr,
    output logic        mem_stall,
    mem_access_stage_if.master dmem,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwr,
    output logic        mem_misalign,
    output logic        mem_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Captured request context, held for the whole transaction
    logic        ld_q, ld_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwr_q, regwr_d;
    logic [31:0] alu_q, alu_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic        wb_valid_d, wb_regwr_d, mis_d, err_d;
    logic [31:0] wb_data_d;
    logic [4:0]  wb_rd_d;

    logic is_mem;

    // op[1:0]: 00 byte, 01 half, anything else word; op[2] selects zero extension
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b00:   be_of = 4'b0001 << off;
            2'b01:   be_of = off[1] ? 4'b1100 : 4'b0011;
            default: be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] op, input logic [31:0] d);
        case (op[1:0])
            2'b00:   wdata_of = {4{d[7:0]}};
            2'b01:   wdata_of = {2{d[15:0]}};
            default: wdata_of = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {off, 3'b000});
        h = 16'(rdata >> {off[1], 4'b0000});
        case (op[1:0])
            2'b00:   load_ext = op[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = op[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_ext = rdata;
        endcase
    endfunction

    assign is_mem = ex_memrd | ex_memwr;

    // Next-state, stall and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_d       = ld_q;
        op_d       = op_q;
        off_d      = off_q;
        rd_d       = rd_q;
        regwr_d    = regwr_q;
        alu_d      = alu_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data;
        wb_rd_d    = wb_rd;
        wb_regwr_d = 1'b0;
        mis_d      = 1'b0;
        err_d      = 1'b0;
        mem_stall  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_aluout;
                        wb_rd_d    = ex_rd;
                        wb_regwr_d = ex_regwr;
                    end else if (misaligned(ex_memop, ex_aluout[1:0])) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_aluout;
                        wb_rd_d    = ex_rd;
                        mis_d      = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        ld_d      = ex_memrd;
                        op_d      = ex_memop;
                        off_d     = ex_aluout[1:0];
                        rd_d      = ex_rd;
                        regwr_d   = ex_regwr;
                        alu_d     = ex_aluout;
                        req_d     = 1'b1;
                        we_d      = !ex_memrd;
                        addr_d    = {ex_aluout[31:2], 2'b00};
                        be_d      = be_of(ex_memop, ex_aluout[1:0]);
                        wdata_d   = wdata_of(ex_memop, ex_busb);
                        state_d   = S_REQ;
                    end
                end
            end

            S_REQ: begin
                mem_stall = 1'b1;
                if (dmem.dmem_gnt && !ld_q) begin
                    mem_stall  = 1'b0;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_q;
                    wb_rd_d    = rd_q;
                    state_d    = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_stall  = 1'b0;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_q;
                    wb_rd_d    = rd_q;
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (dmem.dmem_gnt) begin
                        req_d   = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                mem_stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    mem_stall  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = load_ext(op_q, off_q, dmem.dmem_rdata);
                    wb_rd_d    = rd_q;
                    wb_regwr_d = regwr_q;
                    state_d    = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_stall  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_q;
                    wb_rd_d    = rd_q;
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Nothing is accepted while reset is held, so never stall upstream then
        if (rst) mem_stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ld_q         <= 1'b0;
            op_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            regwr_q      <= 1'b0;
            alu_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_regwr     <= 1'b0;
            mem_misalign <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_q         <= ld_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            regwr_q      <= regwr_d;
            alu_q        <= alu_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            wb_valid     <= wb_valid_d;
            wb_data      <= wb_data_d;
            wb_rd        <= wb_rd_d;
            wb_regwr     <= wb_regwr_d;
            mem_misalign <= mis_d;
            mem_err      <= err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single-cycle cases plus
// hand-driven store/load/timeout/reset sequences against a scripted memory.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_aluout;
    logic [31:0] ex_busb;
    logic        ex_memrd;
    logic        ex_memwr;
    logic [2:0]  ex_memop;
    logic [4:0]  ex_rd;
    logic        ex_regwr;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwr;
    logic        mem_misalign;
    logic        mem_err;

    int checks = 0;
    int failures = 0;

    mem_access_stage_if dif();

    mem_access_stage #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_aluout    (ex_aluout),
        .ex_busb      (ex_busb),
        .ex_memrd     (ex_memrd),
        .ex_memwr     (ex_memwr),
        .ex_memop     (ex_memop),
        .ex_rd        (ex_rd),
        .ex_regwr     (ex_regwr),
        .mem_stall    (mem_stall),
        .dmem         (dif),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_regwr     (wb_regwr),
        .mem_misalign (mem_misalign),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] alu;
        logic        memrd;
        logic        memwr;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        regwr;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_regwr;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Return to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] busb,
                            input logic rd_en, input logic wr_en, input logic [2:0] op,
                            input logic [4:0] rd, input logic regwr);
        ex_valid  = v;
        ex_aluout = alu;
        ex_busb   = busb;
        ex_memrd  = rd_en;
        ex_memwr  = wr_en;
        ex_memop  = op;
        ex_rd     = rd;
        ex_regwr  = regwr;
    endtask

    // One aligned access held in EX until the stall drops; memory answers after given waits
    task automatic mem_txn(input string name, input logic [31:0] alu, input logic [31:0] busb,
                           input logic is_load, input logic [2:0] op, input logic [4:0] rd,
                           input int gnt_wait, input logic stray_rvalid, input int rv_wait,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_data);
        drive_ex(1'b1, alu, busb, is_load, !is_load, op, rd, 1'b1);
        dif.dmem_gnt = 1'b0;
        dif.dmem_rvalid = 1'b0;
        #1;
        chk({name, " idle_stall"}, 32'(mem_stall), 32'd1);
        chk({name, " idle_noreq"}, 32'(dif.dmem_req), 32'd0);
        step();
        for (int i = 0; i <= gnt_wait; i++) begin
            if (i == gnt_wait) begin
                dif.dmem_gnt = 1'b1;
                dif.dmem_rvalid = 1'b0;
            end else if (stray_rvalid) begin
                dif.dmem_rvalid = 1'b1;
                dif.dmem_rdata = 32'hDEAD_DEAD;
            end
            #1;
            chk({name, " req"}, 32'(dif.dmem_req), 32'd1);
            chk({name, " we"}, 32'(dif.dmem_we), 32'(!is_load));
            chk({name, " addr"}, dif.dmem_addr, {alu[31:2], 2'b00});
            if (!is_load) begin
                chk({name, " be"}, 32'(dif.dmem_be), 32'(exp_be));
                chk({name, " wdata"}, dif.dmem_wdata, exp_wdata);
            end
            chk({name, " req_stall"}, 32'(mem_stall), (i == gnt_wait && !is_load) ? 32'd0 : 32'd1);
            step();
        end
        dif.dmem_gnt = 1'b0;
        if (is_load) begin
            #1;
            chk({name, " req_dropped"}, 32'(dif.dmem_req), 32'd0);
            for (int i = 0; i < rv_wait; i++) begin
                chk({name, " resp_stall"}, 32'(mem_stall), 32'd1);
                step();
            end
            dif.dmem_rvalid = 1'b1;
            dif.dmem_rdata = rdata;
            #1;
            chk({name, " resp_release"}, 32'(mem_stall), 32'd0);
            step();
            dif.dmem_rvalid = 1'b0;
        end
        ex_valid = 1'b0;
        #1;
        chk({name, " wb_valid"}, 32'(wb_valid), 32'd1);
        chk({name, " wb_regwr"}, 32'(wb_regwr), 32'(is_load));
        chk({name, " wb_err"}, 32'(mem_err), 32'd0);
        chk({name, " req_idle"}, 32'(dif.dmem_req), 32'd0);
        if (is_load) begin
            chk({name, " wb_data"}, wb_data, exp_data);
            chk({name, " wb_rd"}, 32'(wb_rd), 32'(rd));
        end
        step();
        chk({name, " wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"alu_1234",   1'b1, 32'h0000_1234, 1'b0, 1'b0, 3'b000, 5'd5,  1'b1,
                    1'b1, 32'h0000_1234, 1'b1, 1'b0};
        vecs[1] = '{"lw_mis",     1'b1, 32'h0000_0102, 1'b1, 1'b0, 3'b010, 5'd6,  1'b1,
                    1'b1, 32'h0000_0102, 1'b0, 1'b1};
        vecs[2] = '{"lh_mis",     1'b1, 32'h0000_0101, 1'b1, 1'b0, 3'b001, 5'd7,  1'b1,
                    1'b1, 32'h0000_0101, 1'b0, 1'b1};
        vecs[3] = '{"shu_mis",    1'b1, 32'h0000_0203, 1'b0, 1'b1, 3'b101, 5'd8,  1'b0,
                    1'b1, 32'h0000_0203, 1'b0, 1'b1};
        vecs[4] = '{"op011_mis",  1'b1, 32'h0000_0002, 1'b1, 1'b0, 3'b011, 5'd9,  1'b1,
                    1'b1, 32'h0000_0002, 1'b0, 1'b1};
        vecs[5] = '{"bubble",     1'b0, 32'h0000_0040, 1'b0, 1'b0, 3'b000, 5'd10, 1'b1,
                    1'b0, 32'h0,         1'b0, 1'b0};
        vecs[6] = '{"alu_noreg",  1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'b000, 5'd31, 1'b0,
                    1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[7] = '{"rdwr_mis",   1'b1, 32'h0000_0301, 1'b1, 1'b1, 3'b010, 5'd11, 1'b1,
                    1'b1, 32'h0000_0301, 1'b0, 1'b1};

        rst = 1'b1;
        drive_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        dif.dmem_gnt = 1'b0;
        dif.dmem_rvalid = 1'b0;
        dif.dmem_rdata = 32'd0;
        step();
        step();
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst dmem_req", 32'(dif.dmem_req), 32'd0);
        chk("rst dmem_addr", dif.dmem_addr, 32'd0);
        chk("rst dmem_be", 32'(dif.dmem_be), 32'd0);
        chk("rst flags", {29'd0, mem_stall, mem_misalign, mem_err}, 32'd0);
        rst = 1'b0;
        step();

        // Single-cycle cases: no stall, WB result one edge later
        for (int i = 0; i < 8; i++) begin
            drive_ex(vecs[i].valid, vecs[i].alu, 32'h5555_5555, vecs[i].memrd, vecs[i].memwr,
                     vecs[i].op, vecs[i].rd, vecs[i].regwr);
            #1;
            chk({vecs[i].name, " stall"}, 32'(mem_stall), 32'd0);
            step();
            chk({vecs[i].name, " wb_valid"}, 32'(wb_valid), 32'(vecs[i].exp_valid));
            chk({vecs[i].name, " misalign"}, 32'(mem_misalign), 32'(vecs[i].exp_mis));
            chk({vecs[i].name, " noreq"}, 32'(dif.dmem_req), 32'd0);
            if (vecs[i].exp_valid) begin
                chk({vecs[i].name, " wb_data"}, wb_data, vecs[i].exp_data);
                chk({vecs[i].name, " wb_rd"}, 32'(wb_rd), 32'(vecs[i].rd));
                chk({vecs[i].name, " wb_regwr"}, 32'(wb_regwr), 32'(vecs[i].exp_regwr));
            end
        end
        ex_valid = 1'b0;
        step();

        mem_txn("sb", 32'h0000_0103, 32'h0000_00AB, 1'b0, 3'b000, 5'd1, 0, 1'b0, 0, 32'd0,
                4'b1000, 32'hABAB_ABAB, 32'd0);
        mem_txn("sh", 32'h0000_0206, 32'h1234_BEEF, 1'b0, 3'b001, 5'd2, 2, 1'b0, 0, 32'd0,
                4'b1100, 32'hBEEF_BEEF, 32'd0);
        mem_txn("sw", 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 3'b010, 5'd3, 1, 1'b0, 0, 32'd0,
                4'b1111, 32'hCAFE_F00D, 32'd0);
        mem_txn("lb", 32'h0000_0102, 32'd0, 1'b1, 3'b000, 5'd7, 0, 1'b0, 3, 32'h0080_0000,
                4'b0, 32'd0, 32'hFFFF_FF80);
        mem_txn("lbu", 32'h0000_0102, 32'd0, 1'b1, 3'b100, 5'd8, 1, 1'b1, 0, 32'h0080_0000,
                4'b0, 32'd0, 32'h0000_0080);
        mem_txn("lh", 32'h0000_0206, 32'd0, 1'b1, 3'b001, 5'd9, 0, 1'b0, 1, 32'h8001_0000,
                4'b0, 32'd0, 32'hFFFF_8001);
        mem_txn("lhu", 32'h0000_0204, 32'd0, 1'b1, 3'b101, 5'd10, 0, 1'b0, 0, 32'h1234_9ABC,
                4'b0, 32'd0, 32'h0000_9ABC);
        mem_txn("lw", 32'h0000_0044, 32'd0, 1'b1, 3'b010, 5'd12, 0, 1'b0, 2, 32'h1122_3344,
                4'b0, 32'd0, 32'h1122_3344);

        // Timeout: grant never comes, abort on the 8th busy cycle
        drive_ex(1'b1, 32'h0000_0040, 32'd0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1);
        #1;
        chk("tmo idle_stall", 32'(mem_stall), 32'd1);
        step();
        for (int k = 1; k < 8; k++) begin
            chk("tmo busy_stall", 32'(mem_stall), 32'd1);
            chk("tmo busy_req", 32'(dif.dmem_req), 32'd1);
            step();
        end
        chk("tmo release", 32'(mem_stall), 32'd0);
        step();
        ex_valid = 1'b0;
        #1;
        chk("tmo wb_valid", 32'(wb_valid), 32'd1);
        chk("tmo mem_err", 32'(mem_err), 32'd1);
        chk("tmo wb_regwr", 32'(wb_regwr), 32'd0);
        chk("tmo req_drop", 32'(dif.dmem_req), 32'd0);
        step();
        chk("tmo err_pulse", 32'(mem_err), 32'd0);

        // Reset while waiting for read data
        drive_ex(1'b1, 32'h0000_0020, 32'd0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
        step();
        dif.dmem_gnt = 1'b1;
        step();
        dif.dmem_gnt = 1'b0;
        #1;
        chk("rstx resp_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstx stall", 32'(mem_stall), 32'd0);
        chk("rstx req", 32'(dif.dmem_req), 32'd0);
        chk("rstx addr", dif.dmem_addr, 32'd0);
        chk("rstx wb_valid", 32'(wb_valid), 32'd0);
        ex_valid = 1'b0;
        step();
        chk("rstx no_retire", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        step();
        mem_txn("lw_after_rst", 32'h0000_0024, 32'd0, 1'b1, 3'b010, 5'd13, 0, 1'b0, 0,
                32'h5566_7788, 4'b0, 32'd0, 32'h5566_7788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
